// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be
//   Single-clock true dual-port RAM with per-byte write enables, selectable
//   read-during-write behaviour, 1- or 2-cycle registered read path and a
//   post-reset sweep that zero-fills the array before accesses are accepted.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   init_done         high once the zero-fill sweep is complete
//   en_x/we_x/be_x    access enable, write enable, byte-lane enables (x = a, b)
//   addr_x/din_x      address and write data
//   dout_x            read data (holds between strobes)
//   dout_valid_x      one-cycle strobe marking dout_x
//   collision         registered pulse for a same-address access with a write
module dual_port_ram_be #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 4,
  parameter int BYTE_WIDTH    = 8,
  parameter int RD_LATENCY    = 1,
  parameter int WRITE_MODE    = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  output logic                               init_done,
  input  logic                               en_a,
  input  logic                               we_a,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be_a,
  input  logic [ADDRESS_WIDTH-1:0]           addr_a,
  input  logic [DATA_WIDTH-1:0]              din_a,
  output logic [DATA_WIDTH-1:0]              dout_a,
  output logic                               dout_valid_a,
  input  logic                               en_b,
  input  logic                               we_b,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   be_b,
  input  logic [ADDRESS_WIDTH-1:0]           addr_b,
  input  logic [DATA_WIDTH-1:0]              din_b,
  output logic [DATA_WIDTH-1:0]              dout_b,
  output logic                               dout_valid_b,
  output logic                               collision
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("RD_LATENCY must be 1 or 2");
  end

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0]    mem [DEPTH];

  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] base,
    input logic [DATA_WIDTH-1:0] wdat,
    input logic [NB-1:0]         mask
  );
    logic [DATA_WIDTH-1:0] r;
    r = base;
    for (int i = 0; i < NB; i++) begin
      if (mask[i]) r[i*BYTE_WIDTH +: BYTE_WIDTH] = wdat[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == S_CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == ADDRESS_WIDTH'(DEPTH - 1)) state_d = S_READY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign init_done = (state_q == S_READY);

  // ---- stage p0: access decode, collision merge, array update ----
  logic                  acc_a_p0, acc_b_p0, wr_a_p0, wr_b_p0, same_p0;
  logic [NB-1:0]         wm_a_p0, wm_b_p0, sh_a_p0, sh_b_p0;
  logic [DATA_WIDTH-1:0] old_a_p0, old_b_p0, new_a_p0, new_b_p0;
  logic [DATA_WIDTH-1:0] rsel_a_p0, rsel_b_p0;

  always_comb begin
    acc_a_p0 = init_done & en_a;
    acc_b_p0 = init_done & en_b;
    wr_a_p0  = acc_a_p0 & we_a;
    wr_b_p0  = acc_b_p0 & we_b;
    same_p0  = acc_a_p0 & acc_b_p0 & (addr_a == addr_b);
    wm_a_p0  = wr_a_p0 ? be_a : '0;
    wm_b_p0  = wr_b_p0 ? be_b : '0;
    // Lanes the other port contributes to a shared word; port A wins overlaps.
    sh_a_p0  = same_p0 ? wm_a_p0 : '0;
    sh_b_p0  = same_p0 ? (wm_b_p0 & ~wm_a_p0) : '0;
    old_a_p0 = mem[addr_a];
    old_b_p0 = mem[addr_b];
    new_a_p0 = lane_merge(lane_merge(old_a_p0, din_a, wm_a_p0), din_b, sh_b_p0);
    new_b_p0 = lane_merge(lane_merge(old_b_p0, din_b, wm_b_p0 & ~sh_a_p0), din_a, sh_a_p0);
    rsel_a_p0 = (WRITE_MODE != 0) ? new_a_p0 : old_a_p0;
    rsel_b_p0 = (WRITE_MODE != 0) ? new_b_p0 : old_b_p0;
  end

  // On a shared address new_a_p0 == new_b_p0, so a single write covers both.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem[ptr_q] <= '0;
    end else begin
      if (wr_a_p0 || (wr_b_p0 && same_p0)) mem[addr_a] <= new_a_p0;
      if (wr_b_p0 && !same_p0)             mem[addr_b] <= new_b_p0;
    end
  end

  // ---- stage p1: first registered read stage ----
  logic                  vld_a_p1_q, vld_b_p1_q, collision_q;
  logic [DATA_WIDTH-1:0] dat_a_p1_q, dat_b_p1_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_a_p1_q  <= 1'b0;
      vld_b_p1_q  <= 1'b0;
      dat_a_p1_q  <= '0;
      dat_b_p1_q  <= '0;
      collision_q <= 1'b0;
    end else begin
      vld_a_p1_q  <= acc_a_p0;
      vld_b_p1_q  <= acc_b_p0;
      if (acc_a_p0) dat_a_p1_q <= rsel_a_p0;
      if (acc_b_p0) dat_b_p1_q <= rsel_b_p0;
      collision_q <= same_p0 & (wr_a_p0 | wr_b_p0);
    end
  end

  assign collision = collision_q;

  // ---- stage p2: optional second read stage ----
  if (RD_LATENCY == 2) begin : g_lat2
    logic                  vld_a_p2_q, vld_b_p2_q;
    logic [DATA_WIDTH-1:0] dat_a_p2_q, dat_b_p2_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_a_p2_q <= 1'b0;
        vld_b_p2_q <= 1'b0;
        dat_a_p2_q <= '0;
        dat_b_p2_q <= '0;
      end else begin
        vld_a_p2_q <= vld_a_p1_q;
        vld_b_p2_q <= vld_b_p1_q;
        if (vld_a_p1_q) dat_a_p2_q <= dat_a_p1_q;
        if (vld_b_p1_q) dat_b_p2_q <= dat_b_p1_q;
      end
    end

    assign dout_a       = dat_a_p2_q;
    assign dout_b       = dat_b_p2_q;
    assign dout_valid_a = vld_a_p2_q;
    assign dout_valid_b = vld_b_p2_q;
  end else begin : g_lat1
    assign dout_a       = dat_a_p1_q;
    assign dout_b       = dat_b_p1_q;
    assign dout_valid_a = vld_a_p1_q;
    assign dout_valid_b = vld_b_p1_q;
  end

endmodule
